// File: rtl/jb_resolve_unit.sv
// jb_resolve_unit: EX-stage jump/branch resolution with registered redirect and a direct-mapped BTB when JB_BTB_EN is defined
module jb_resolve_unit #(
  parameter int XLEN = 32,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [4:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] ex_link,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam logic [4:0] OP_JAL = 5'b11011, OP_JALR = 5'b11001, OP_BRANCH = 5'b11000;
  logic resolve, is_jal, is_jalr, is_br, is_jb, eq, lt, ltu, cond, taken, mispred;
  logic [XLEN-1:0] target;
  assign ex_link = ex_pc + XLEN'(4);
  always_comb begin
    resolve = ex_valid & ~ex_stall & ~redirect_valid;
    is_jal = ex_opcode == OP_JAL;
    is_jalr = ex_opcode == OP_JALR;
    is_br = ex_opcode == OP_BRANCH;
    is_jb = is_jal | is_jalr | is_br;
    target = is_jalr ? (ex_rs1 + ex_imm) & ~XLEN'(1) : ex_pc + ex_imm;
    eq = ex_rs1 == ex_rs2;
    lt = $signed(ex_rs1) < $signed(ex_rs2);
    ltu = ex_rs1 < ex_rs2;
    cond = ex_funct3[2:1] == 2'b00 ? eq ^ ex_funct3[0] :
           ex_funct3[2:1] == 2'b10 ? lt ^ ex_funct3[0] :
           ex_funct3[2:1] == 2'b11 ? ltu ^ ex_funct3[0] : 1'b0;
    taken = is_jal | is_jalr | (is_br & cond);
    mispred = (taken != ex_pred_taken) | (taken & ex_pred_taken & (target != ex_pred_target));
  end
  always_ff @(posedge clk)
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      misalign <= 1'b0;
      branch_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      redirect_valid <= resolve & mispred;
      if (resolve & mispred) redirect_pc <= taken ? target : ex_link;
      misalign <= resolve & taken & target[1];
      if (resolve & is_jb & ~&branch_cnt) branch_cnt <= branch_cnt + CNT_W'(1);
      if (resolve & mispred & ~&mispred_cnt) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
`ifdef JB_BTB_EN
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;
  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag [BTB_DEPTH];
  logic [XLEN-1:0] btb_target [BTB_DEPTH];
  logic [IDX-1:0] rd_idx, wr_idx;
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^if_pc[1:0];
  assign rd_idx = if_pc[IDX+1:2];
  assign wr_idx = ex_pc[IDX+1:2];
  assign if_pred_taken = btb_valid[rd_idx] && btb_tag[rd_idx] == if_pc[XLEN-1:IDX+2];
  assign if_pred_target = if_pred_taken ? btb_target[rd_idx] : '0;
  always_ff @(posedge clk)
    if (rst) btb_valid <= '0;
    else if (resolve & taken) btb_valid[wr_idx] <= 1'b1;
    else if (resolve & ex_pred_taken) btb_valid[wr_idx] <= 1'b0;
  always_ff @(posedge clk)
    if (~rst & resolve & taken) begin
      btb_tag[wr_idx] <= ex_pc[XLEN-1:IDX+2];
      btb_target[wr_idx] <= target;
    end
`else
  logic unused_if_pc;
  assign unused_if_pc = ^if_pc;
  assign if_pred_taken = 1'b0;
  assign if_pred_target = '0;
`endif
endmodule

// File: tb/tb_jb_resolve_unit.sv
// tb_jb_resolve_unit: directed vector table plus hand sequences for squash, stall, reset and BTB behaviour
module tb_jb_resolve_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic if_pred_taken;
  logic [31:0] if_pred_target;
  logic ex_valid = 1'b0, ex_stall = 1'b0;
  logic [4:0] ex_opcode = '0;
  logic [2:0] ex_funct3 = '0;
  logic [31:0] ex_pc = '0, ex_rs1 = '0, ex_rs2 = '0, ex_imm = '0;
  logic ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic [31:0] ex_link;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic misalign;
  logic [31:0] branch_cnt, mispred_cnt;
  int passed = 0, total = 0;
  int exp_br = 0, exp_mp = 0;
  localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000, ALU = 5'b01100;
  localparam bit BTB = `ifdef JB_BTB_EN 1'b1 `else 1'b0 `endif;
  typedef struct {
    logic [4:0] op;
    logic [2:0] f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic pt;
    logic [31:0] ptgt;
    logic rv;
    logic [31:0] rpc;
    logic mis;
    logic [31:0] link;
  } vec_t;
  vec_t tbl [14];
  jb_resolve_unit dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_link(ex_link), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign(misalign), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  task automatic drive(input vec_t v);
    ex_valid = 1'b1;
    ex_opcode = v.op;
    ex_funct3 = v.f3;
    ex_pc = v.pc;
    ex_rs1 = v.rs1;
    ex_rs2 = v.rs2;
    ex_imm = v.imm;
    ex_pred_taken = v.pt;
    ex_pred_target = v.ptgt;
  endtask
  task automatic apply(input int i, input vec_t v);
    drive(v);
    #1 chk($sformatf("link[%0d]", i), ex_link, v.link);
    @(posedge clk); #1;
    chk($sformatf("redirect_valid[%0d]", i), {31'b0, redirect_valid}, {31'b0, v.rv});
    if (v.rv) chk($sformatf("redirect_pc[%0d]", i), redirect_pc, v.rpc);
    chk($sformatf("misalign[%0d]", i), {31'b0, misalign}, {31'b0, v.mis});
    if (v.op == JAL || v.op == JALR || v.op == BR) exp_br++;
    if (v.rv) exp_mp++;
    ex_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    tbl[0]  = '{JAL,  3'b000, 32'h100, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0, 1'b1, 32'h120, 1'b0, 32'h104};
    tbl[1]  = '{JALR, 3'b000, 32'h200, 32'h2001, 32'h0, 32'h4, 1'b0, 32'h0, 1'b1, 32'h2004, 1'b0, 32'h204};
    tbl[2]  = '{JALR, 3'b000, 32'h204, 32'h2002, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2002, 1'b1, 32'h208};
    tbl[3]  = '{BR, 3'b100, 32'h300, 32'hFFFFFFFF, 32'h1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h340, 1'b0, 32'h304};
    tbl[4]  = '{BR, 3'b110, 32'h304, 32'hFFFFFFFF, 32'h1, 32'h40, 1'b1, 32'h344, 1'b1, 32'h308, 1'b0, 32'h308};
    tbl[5]  = '{BR, 3'b000, 32'h400, 32'h5, 32'h5, 32'hFFFFFFF8, 1'b1, 32'h3F8, 1'b0, 32'h0, 1'b0, 32'h404};
    tbl[6]  = '{BR, 3'b001, 32'h404, 32'h5, 32'h5, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h408};
    tbl[7]  = '{BR, 3'b101, 32'h500, 32'h1, 32'hFFFFFFFF, 32'h10, 1'b1, 32'h999, 1'b1, 32'h510, 1'b0, 32'h504};
    tbl[8]  = '{BR, 3'b111, 32'h504, 32'h1, 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h508};
    tbl[9]  = '{BR, 3'b010, 32'h508, 32'h1, 32'h7, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h50C};
    tbl[10] = '{ALU, 3'b000, 32'h600, 32'h0, 32'h0, 32'h0, 1'b1, 32'h700, 1'b1, 32'h604, 1'b0, 32'h604};
    tbl[11] = '{JAL, 3'b000, 32'h700, 32'h0, 32'h0, 32'h6, 1'b1, 32'h706, 1'b0, 32'h0, 1'b1, 32'h704};
    tbl[12] = '{JAL, 3'b000, 32'hFFFFFFF0, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'hFFFFFFF4};
    tbl[13] = '{5'b00000, 3'b000, 32'h800, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h804};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    chk("reset misalign", {31'b0, misalign}, 32'h0);
    chk("reset branch_cnt", branch_cnt, 32'h0);
    chk("reset mispred_cnt", mispred_cnt, 32'h0);
    if_pc = 32'h100;
    #1 chk("reset if_pred_taken", {31'b0, if_pred_taken}, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) apply(i, tbl[i]);
    chk("table branch_cnt", branch_cnt, 32'(exp_br));
    chk("table mispred_cnt", mispred_cnt, 32'(exp_mp));
    // BTB trained by a JAL must hit at its PC right after the resolve edge
    apply(0, tbl[0]);
    if_pc = 32'h100;
    #1 chk("btb hit", {31'b0, if_pred_taken}, {31'b0, BTB});
    chk("btb target", if_pred_target, BTB ? 32'h120 : 32'h0);
    if_pc = 32'h140;
    #1 chk("btb tag miss", {31'b0, if_pred_taken}, 32'h0);
    // squash: second mispredicting JAL held during the redirect cycle is ignored
    drive('{JAL, 3'b000, 32'h900, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
    @(posedge clk); #1;
    chk("squash first redirect", {31'b0, redirect_valid}, 32'h1);
    chk("squash first pc", redirect_pc, 32'h910);
    drive('{JAL, 3'b000, 32'hA00, 32'h0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
    @(posedge clk); #1;
    chk("squash second ignored", {31'b0, redirect_valid}, 32'h0);
    ex_valid = 1'b0;
    exp_br++; exp_mp++;
    chk("squash branch_cnt", branch_cnt, 32'(exp_br));
    chk("squash mispred_cnt", mispred_cnt, 32'(exp_mp));
    @(posedge clk); #1;
    // stall three cycles, then resolve on the first free cycle
    drive('{JAL, 3'b000, 32'hB00, 32'h0, 32'h0, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall no redirect[%0d]", c), {31'b0, redirect_valid}, 32'h0);
    end
    chk("stall no count", branch_cnt, 32'(exp_br));
    ex_stall = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("stall redirect", {31'b0, redirect_valid}, 32'h1);
    chk("stall redirect_pc", redirect_pc, 32'hB08);
    exp_br++; exp_mp++;
    chk("stall branch_cnt", branch_cnt, 32'(exp_br));
    @(posedge clk); #1;
    chk("redirect is one pulse", {31'b0, redirect_valid}, 32'h0);
    // reset during a resolve cycle suppresses redirect, counts and BTB write
    drive('{JAL, 3'b000, 32'hC00, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    chk("rst resolve redirect", {31'b0, redirect_valid}, 32'h0);
    chk("rst resolve branch_cnt", branch_cnt, 32'h0);
    chk("rst resolve mispred_cnt", mispred_cnt, 32'h0);
    if_pc = 32'hC00;
    #1 chk("rst btb empty new", {31'b0, if_pred_taken}, 32'h0);
    if_pc = 32'h100;
    #1 chk("rst btb empty old", {31'b0, if_pred_taken}, 32'h0);
    @(posedge clk); #1;
    chk("rst no late redirect", {31'b0, redirect_valid}, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
